cd_port_sched4: RTL and testbench

- 4-requester, 1-output scheduler for a single output port of the cardinal mesh router.
- Round-robin arbitration between four input ports, fair at packet granularity.
- Holds the grant on the winning input until that input's tail flit has transferred (wormhole-style lock).
- Registers the selected flit into a single-entry output stage with a valid/ready handshake toward the downstream link or next-hop buffer.

---
 rtl/cd_port_sched4.sv | 197 +++++++++++++++++++
 tb/tb_cd_port_sched4.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cd_port_sched4.sv
// cd_port_sched4: four-input, one-output scheduler for one output port of the
// cardinal mesh router. Round-robin arbitration at packet granularity: the
// winner stays locked until its tail flit has been accepted (wormhole-style).
// The granted flit goes into a single-entry output register that uses a
// valid/ready handshake.
//
// Optional feature: define CD_SCHED_TIMEOUT_EN to add a lock watchdog. The lock
// is dropped after TIMEOUT idle owner cycles, and err_timeout pulses once.
//
// Ports:
//   clk, reset    rising-edge clock, asynchronous active-low reset
//   in_valid[4]   per-requester flit valid
//   in_data       per-requester flits, requester i at [i*DATA_W +: DATA_W]
//   in_tail[4]    per-requester last-flit flag
//   in_ready[4]   combinational grant, one-hot or zero
//   out_valid     output register holds a flit
//   out_data      registered flit
//   out_tail      registered tail flag
//   out_ready     downstream accepts the flit
//   busy          1 while a packet lock is held
//   lock_owner    current (or last) lock holder
//   err_timeout   one-cycle watchdog release pulse (0 when compiled out)
module cd_port_sched4 #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            in_valid,
  input  logic [4*DATA_W-1:0]   in_data,
  input  logic [3:0]            in_tail,
  output logic [3:0]            in_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_tail,
  input  logic                  out_ready,
  output logic                  busy,
  output logic [1:0]            lock_owner,
  output logic                  err_timeout
);

  localparam int unsigned PTR_W = 2;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_e;

  // TIMEOUT sizes the watchdog; reject values the 8-bit counter cannot reach.
  if ((TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_timeout_range
    $error("cd_port_sched4: TIMEOUT must be in 2..255");
  end

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    lock_owner_q, lock_owner_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_tail_q, out_tail_d;

`ifdef CD_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = 8;
  logic [CNT_W-1:0]    idle_cnt_q, idle_cnt_d;
  logic                err_timeout_q, err_timeout_d;
`endif

  logic                slot_free;
  logic                win_found;
  logic [PTR_W-1:0]    win_idx;
  logic [PTR_W-1:0]    cand;
  logic                grant_vld;
  logic [PTR_W-1:0]    grant_idx;
  logic [DATA_W-1:0]   sel_data;
  logic                sel_tail;

  // The output slot can take a flit when empty or when draining this cycle.
  assign slot_free = !out_valid_q || out_ready;

  // Round-robin search: first valid requester starting at ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + PTR_W'(k);
      if (!win_found && in_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Grant: the round-robin winner while idle, only the owner while locked.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = win_idx;
    if (state_q == S_IDLE) begin
      grant_vld = slot_free && win_found;
      grant_idx = win_idx;
    end else begin
      grant_vld = slot_free && in_valid[lock_owner_q];
      grant_idx = lock_owner_q;
    end
  end

  assign in_ready = grant_vld ? (4'b0001 << grant_idx) : 4'b0000;
  assign sel_data = in_data[32'(grant_idx) * DATA_W +: DATA_W];
  assign sel_tail = in_tail[grant_idx];

  // Next-state logic for the arbiter, the lock and the output register.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    lock_owner_d = lock_owner_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_tail_d   = out_tail_q;
`ifdef CD_SCHED_TIMEOUT_EN
    idle_cnt_d    = idle_cnt_q;
    err_timeout_d = 1'b0;
`endif
    if (grant_vld) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_tail_d  = sel_tail;
`ifdef CD_SCHED_TIMEOUT_EN
      idle_cnt_d  = '0;
`endif
      if (state_q == S_IDLE) begin
        if (sel_tail) begin
          ptr_d = grant_idx + PTR_W'(1);
        end else begin
          state_d      = S_LOCKED;
          lock_owner_d = grant_idx;
        end
      end else if (sel_tail) begin
        state_d = S_IDLE;
        ptr_d   = lock_owner_q + PTR_W'(1);
      end
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
`ifdef CD_SCHED_TIMEOUT_EN
      // Watchdog: count owner bubbles; release the lock when the limit is hit.
      if ((state_q == S_LOCKED) && !in_valid[lock_owner_q]) begin
        if ((idle_cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT)) begin
          state_d       = S_IDLE;
          ptr_d         = lock_owner_q + PTR_W'(1);
          idle_cnt_d    = '0;
          err_timeout_d = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      lock_owner_q  <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_tail_q    <= 1'b0;
`ifdef CD_SCHED_TIMEOUT_EN
      idle_cnt_q    <= '0;
      err_timeout_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      lock_owner_q  <= lock_owner_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_tail_q    <= out_tail_d;
`ifdef CD_SCHED_TIMEOUT_EN
      idle_cnt_q    <= idle_cnt_d;
      err_timeout_q <= err_timeout_d;
`endif
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_tail   = out_tail_q;
  assign busy       = (state_q == S_LOCKED);
  assign lock_owner = lock_owner_q;
`ifdef CD_SCHED_TIMEOUT_EN
  assign err_timeout = err_timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cd_port_sched4.sv
// Testbench for cd_port_sched4: directed scenarios plus randomized traffic,
// checked every cycle against a packet-level reference model.
module tb_cd_port_sched4;

  localparam int unsigned DW = 64;
  localparam int unsigned TO = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      in_valid;
  logic [4*DW-1:0] in_data;
  logic [3:0]      in_tail;
  logic [3:0]      in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_tail;
  logic            out_ready;
  logic            busy;
  logic [1:0]      lock_owner;
  logic            err_timeout;

  cd_port_sched4 #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_tail    (in_tail),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_tail   (out_tail),
    .out_ready  (out_ready),
    .busy       (busy),
    .lock_owner (lock_owner),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: packet-level scheduler state.
  bit            m_lock;
  int            m_owner;
  int            m_ptr;
  int            m_cnt;
  bit            m_ov;
  bit            m_ot;
  bit            m_err;
  logic [DW-1:0] m_od;
  logic [DW-1:0] d [4];

  task automatic m_reset();
    m_lock = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
    m_ov = 0; m_ot = 0; m_err = 0; m_od = '0;
  endtask

  // One clock cycle: drive inputs, check grants, advance the model, check outputs.
  task automatic step(input logic [3:0] iv, input logic [3:0] tl, input bit ordy);
    int         g;
    bit         slot;
    logic [3:0] er;
    in_valid  = iv;
    in_tail   = tl;
    out_ready = ordy;
    for (int i = 0; i < 4; i++) begin
      d[i] = {$urandom, $urandom};
      in_data[i*DW +: DW] = d[i];
    end
    #1;
    slot = !m_ov || ordy;
    g = -1;
    if (slot) begin
      if (!m_lock) begin
        for (int k = 0; k < 4; k++)
          if (g < 0 && iv[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      end else if (iv[m_owner]) begin
        g = m_owner;
      end
    end
    er = (g >= 0) ? 4'(1 << g) : 4'b0000;
    chk_val("in_ready", 64'(in_ready), 64'(er));
    chk_val("ready_only_if_valid", 64'(in_ready & ~iv), 64'd0);
    m_err = 0;
    if (g >= 0) begin
      m_ov = 1;
      m_od = d[g];
      m_ot = tl[g];
      m_cnt = 0;
      if (!m_lock) begin
        if (tl[g]) m_ptr = (g + 1) % 4;
        else begin
          m_lock  = 1;
          m_owner = g;
        end
      end else if (tl[g]) begin
        m_lock = 0;
        m_ptr  = (m_owner + 1) % 4;
      end
    end else begin
      if (m_ov && ordy) m_ov = 0;
`ifdef CD_SCHED_TIMEOUT_EN
      if (m_lock && !iv[m_owner]) begin
        m_cnt++;
        if (m_cnt == TO) begin
          m_lock = 0;
          m_ptr  = (m_owner + 1) % 4;
          m_cnt  = 0;
          m_err  = 1;
        end
      end
`endif
    end
    @(posedge clk);
    #1;
    chk_val("out_valid", 64'(out_valid), 64'(m_ov));
    chk_val("out_data", out_data, m_od);
    chk_val("out_tail", 64'(out_tail), 64'(m_ot));
    chk_val("busy", 64'(busy), 64'(m_lock));
    chk_val("lock_owner", 64'(lock_owner), 64'(m_owner));
    chk_val("err_timeout", 64'(err_timeout), 64'(m_err));
  endtask

  task automatic check_reset_state(input string tag);
    chk_val({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk_val({tag, "_out_data"}, out_data, 64'd0);
    chk_val({tag, "_busy"}, 64'(busy), 64'd0);
    chk_val({tag, "_lock_owner"}, 64'(lock_owner), 64'd0);
    chk_val({tag, "_err"}, 64'(err_timeout), 64'd0);
  endtask

  task automatic do_reset();
    in_valid = '0; in_tail = '0; in_data = '0; out_ready = 1'b0;
    reset = 1'b0;
    #1;
    check_reset_state("rst");
    chk_val("rst_in_ready", 64'(in_ready), 64'd0);
    m_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    do_reset();

    // Idle after reset: nothing granted, nothing valid.
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b0000, 4'b0000, 1'b1);

    // All requesters with single-flit packets: grants rotate 0,1,2,3,0.
    for (int i = 0; i < 5; i++) step(4'b1111, 4'b1111, 1'b1);
    // ptr is now 1; a single grant to 1 moves it to 2.
    step(4'b0010, 4'b1111, 1'b1);

    // Requester 2 sends a 3-flit packet while 0 and 3 also request.
    step(4'b1101, 4'b1001, 1'b1);
    step(4'b1101, 4'b1001, 1'b1);
    step(4'b1101, 4'b1101, 1'b1);
    step(4'b1001, 4'b1001, 1'b1);
    step(4'b1001, 4'b1001, 1'b1);

    // Downstream stall for 4 cycles, then release.
    for (int i = 0; i < 4; i++) step(4'b1111, 4'b1111, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b1111, 4'b1111, 1'b1);
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b0000, 4'b0000, 1'b1);

    // Asynchronous reset in the middle of a packet owned by requester 1.
    do_reset();
    step(4'b0010, 4'b0000, 1'b1);
    step(4'b0010, 4'b0000, 1'b1);
    chk_val("mid_busy_before", 64'(busy), 64'd1);
    in_valid = '0;
    reset = 1'b0;
    #1;
    check_reset_state("async_rst");
    m_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    step(4'b1111, 4'b1111, 1'b1);

    // Owner 1 stalls after its head flit while requester 2 waits.
    do_reset();
    step(4'b0010, 4'b0000, 1'b1);
    for (int i = 0; i < TO + 4; i++) step(4'b0100, 4'b0100, 1'b1);
    step(4'b0110, 4'b0110, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      logic [3:0] iv;
      logic [3:0] tl;
      iv = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) tl[i] = ($urandom_range(0, 2) == 0);
      step(iv, tl, $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
